// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate: sums one window of len products and emits one result.
// Define MAC_SAT_EN for saturating accumulation with a per-window overflow flag; default is wrap-around.
module mac_pipe #(
  parameter int WIDTH_A   = 8,
  parameter int WIDTH_B   = 8,
  parameter int ACC_WIDTH = 24,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_mac,
  input  logic                 clear,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [WIDTH_A-1:0]   a,
  input  logic [WIDTH_B-1:0]   b,
  input  logic                 valid_in,
  output logic [ACC_WIDTH-1:0] data_out,
  output logic                 valid_out,
  output logic                 busy,
  output logic                 overflow
);

  localparam int PW = WIDTH_A + WIDTH_B;

  // Handshake: valid-only, no ready. A term is consumed on every rising edge where
  // valid_in & en_mac & ~clear; valid_out is a one-cycle pulse the sink must take.

  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, len_q, len_d;
  logic [LEN_WIDTH-1:0] len_eff, win_len, cnt_inc;
  logic                 accept, is_first, is_last;

  always_comb begin
    accept   = valid_in & en_mac & ~clear;
    len_eff  = (len == '0) ? LEN_WIDTH'(1) : len;
    is_first = (cnt_q == '0);
    win_len  = is_first ? len_eff : len_q;
    cnt_inc  = cnt_q + LEN_WIDTH'(1);
    is_last  = (cnt_inc == win_len);
    cnt_d    = cnt_q;
    len_d    = len_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      if (is_first) len_d = len_eff;
      cnt_d = is_last ? '0 : cnt_inc;
    end
  end

  logic signed [WIDTH_A-1:0] s1_a_q;
  logic signed [WIDTH_B-1:0] s1_b_q;
  logic                      s1_v_q, s1_first_q, s1_last_q;
  logic signed [PW-1:0]      s2_prod_q;
  logic                      s2_v_q, s2_first_q, s2_last_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= '0;
      len_q      <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_prod_q  <= '0;
      s2_v_q     <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_v_q     <= accept;
      s1_first_q <= is_first;
      s1_last_q  <= is_last;
      s2_prod_q  <= PW'(s1_a_q) * PW'(s1_b_q);
      s2_v_q     <= s1_v_q & ~clear;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
    end
  end

  logic signed [ACC_WIDTH-1:0] prod_ext, sum, acc_q, acc_d, data_q, data_d;
  logic                        vout_q, vout_d;

`ifdef MAC_SAT_EN
  logic signed [ACC_WIDTH:0] base_wide, sum_wide;
  logic                      sat_hit, flag_new;
  logic                      win_ovf_q, win_ovf_d, ovf_q, ovf_d;

  // One guard bit detects overflow; a first-tagged product adds to zero so loads saturate too.
  always_comb begin
    prod_ext  = ACC_WIDTH'(s2_prod_q);
    base_wide = s2_first_q ? '0 : (ACC_WIDTH+1)'(acc_q);
    sum_wide  = base_wide + (ACC_WIDTH+1)'(prod_ext);
    sat_hit   = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    if (!sat_hit)
      sum = sum_wide[ACC_WIDTH-1:0];
    else if (sum_wide[ACC_WIDTH])
      sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    flag_new  = (s2_first_q ? 1'b0 : win_ovf_q) | sat_hit;
    vout_d    = s2_v_q & s2_last_q & ~clear;
    win_ovf_d = win_ovf_q;
    if (clear)       win_ovf_d = 1'b0;
    else if (s2_v_q) win_ovf_d = flag_new;
    ovf_d     = vout_d & flag_new;
    acc_d     = s2_v_q ? sum : acc_q;
    data_d    = vout_d ? sum : data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_ovf_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      win_ovf_q <= win_ovf_d;
      ovf_q     <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  always_comb begin
    prod_ext = ACC_WIDTH'(s2_prod_q);
    sum      = s2_first_q ? prod_ext : acc_q + prod_ext;
    vout_d   = s2_v_q & s2_last_q & ~clear;
    acc_d    = s2_v_q ? sum : acc_q;
    data_d   = vout_d ? sum : data_q;
  end

  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q  <= '0;
      data_q <= '0;
      vout_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      data_q <= data_d;
      vout_q <= vout_d;
    end
  end

  // Anything still in the counter or pipeline belongs to a window whose result is not out yet.
  assign busy      = (cnt_q != '0) | s1_v_q | s2_v_q;
  assign data_out  = data_q;
  assign valid_out = vout_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed testbench for mac_pipe (ACC_WIDTH=16) with a scoreboard of expected window results
// and their arrival cycles; expectations for the saturating case follow MAC_SAT_EN.
module tb_mac_pipe;

  logic        clk = 1'b0;
  logic        reset, en_mac, clear, valid_in;
  logic [7:0]  len, a_r, b_r;
  logic [15:0] data_out;
  logic        valid_out, busy, overflow;

  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [16:0] exp_q[$];
  int          exp_t_q[$];
  logic [16:0] mon_e;
  int          mon_t;

  mac_pipe #(
    .WIDTH_A(8), .WIDTH_B(8), .ACC_WIDTH(16), .LEN_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .en_mac(en_mac), .clear(clear), .len(len),
    .a(a_r), .b(b_r), .valid_in(valid_in), .data_out(data_out),
    .valid_out(valid_out), .busy(busy), .overflow(overflow)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Driver tasks: inputs change 2 time units after the rising edge
  task automatic drive(input logic v, input int ta, input int tb_, input int tl,
                       input logic te, input logic tc);
    @(posedge clk);
    #2;
    valid_in = v;
    a_r      = 8'(ta);
    b_r      = 8'(tb_);
    len      = 8'(tl);
    en_mac   = te;
    clear    = tc;
  endtask

  task automatic term(input int ta, input int tb_, input int tl);
    drive(1'b1, ta, tb_, tl, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  // Called right after driving a window's last term: accepted next edge, result 2 edges later.
  task automatic push_exp(input int v, input logic o);
    exp_q.push_back({o, 16'(v)});
    exp_t_q.push_back(cyc + 3);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (valid_out) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid_out", valid_out, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        chk("data_out", data_out, mon_e[15:0]);
        chk("overflow", overflow, mon_e[16]);
        chk("latency_cycle", cyc, mon_t);
      end
    end
  end

  initial begin
    reset = 1'b0; en_mac = 1'b0; clear = 1'b0; valid_in = 1'b0;
    len = '0; a_r = '0; b_r = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_data_out", data_out, 0);
    chk("reset_valid_out", valid_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_overflow", overflow, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    en_mac = 1'b1;

    // len=3 mixed signs
    term(2, 5, 3);
    term(-3, 6, 3);
    @(negedge clk);
    chk("busy_mid_window", busy, 1);
    term(4, -7, 3);
    push_exp(-36, 1'b0);
    idle(4);
    @(negedge clk);
    chk("busy_after_pulse", busy, 0);
    chk("valid_out_deasserted", valid_out, 0);
    chk("data_out_hold", data_out, 16'hffdc);

    // len=1 back-to-back
    for (int i = 1; i <= 4; i++) begin
      term(i, 1, 1);
      push_exp(i, 1'b0);
    end
    idle(4);

    // len=4 with gaps, an en_mac=0 cycle and len changed mid-window
    term(3, 3, 4);
    idle(1);
    drive(1'b1, 3, 3, 4, 1'b0, 1'b0);
    term(3, 3, 2);
    @(negedge clk);
    chk("busy_during_gaps", busy, 1);
    idle(2);
    term(3, 3, 2);
    idle(2);
    term(3, 3, 2);
    push_exp(36, 1'b0);
    idle(4);

    // Accumulator overflow, then flag reset on the next window, then len=0 as 1
    for (int i = 0; i < 4; i++) term(-128, -128, 4);
`ifdef MAC_SAT_EN
    push_exp(32767, 1'b1);
`else
    push_exp(0, 1'b0);
`endif
    term(1, 1, 1);
    push_exp(1, 1'b0);
    term(5, -2, 0);
    push_exp(-10, 1'b0);
    idle(4);

    // clear with a simultaneous valid_in aborts the window
    term(1, 1, 3);
    term(1, 1, 3);
    drive(1'b1, 1, 1, 3, 1'b1, 1'b1);
    idle(1);
    @(negedge clk);
    chk("busy_after_clear", busy, 0);
    for (int i = 0; i < 3; i++) term(1, 1, 3);
    push_exp(3, 1'b0);
    idle(4);

    // reset mid-window
    term(2, 2, 3);
    term(2, 2, 3);
    @(posedge clk);
    #2 reset = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midreset_data_out", data_out, 0);
    chk("midreset_valid_out", valid_out, 0);
    chk("midreset_busy", busy, 0);
    for (int i = 0; i < 3; i++) term(2, 2, 3);
    push_exp(12, 1'b0);
    idle(5);
    @(negedge clk);
    chk("final_data_out_hold", data_out, 12);
    chk("all_results_seen", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
